// File: rtl/freq_ctrl_pkg.sv
// Shared constants and state encoding for the frequency setpoint sequencer.
package freq_ctrl_pkg;

    localparam int F_LO_MIN = 1;
    localparam int F_LO_MAX = 100;
    localparam int F_HI_MIN = 1000;
    localparam int F_HI_MAX = 2000;
    localparam int STEP_LO  = 1;
    localparam int STEP_HI  = 100;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OFFER = 2'd1,
        DWELL = 2'd2
    } state_t;

endpackage

// File: rtl/freq_step_calc.sv
// Combinational one-step neighbour of a (freq, mode) setpoint, wrapping across the two ranges.
module freq_step_calc
    import freq_ctrl_pkg::*;
#(
    parameter int FREQ_W = 12
) (
    input  logic [FREQ_W-1:0] freq,
    input  logic              mode,
    input  logic              up,
    output logic [FREQ_W-1:0] next_freq,
    output logic              next_mode,
    output logic              wrap
);

    // Range limits use >= / <= so an out-of-range value can never step further out.
    always_comb begin
        next_freq = freq;
        next_mode = mode;
        wrap      = 1'b0;
        if (up) begin
            if (!mode) begin
                if (freq >= FREQ_W'(F_LO_MAX)) begin
                    next_freq = FREQ_W'(F_HI_MIN);
                    next_mode = 1'b1;
                    wrap      = 1'b1;
                end else begin
                    next_freq = freq + FREQ_W'(STEP_LO);
                end
            end else begin
                if (freq >= FREQ_W'(F_HI_MAX)) begin
                    next_freq = FREQ_W'(F_LO_MIN);
                    next_mode = 1'b0;
                    wrap      = 1'b1;
                end else begin
                    next_freq = freq + FREQ_W'(STEP_HI);
                end
            end
        end else begin
            if (!mode) begin
                if (freq <= FREQ_W'(F_LO_MIN)) begin
                    next_freq = FREQ_W'(F_HI_MAX);
                    next_mode = 1'b1;
                    wrap      = 1'b1;
                end else begin
                    next_freq = freq - FREQ_W'(STEP_LO);
                end
            end else begin
                if (freq <= FREQ_W'(F_HI_MIN)) begin
                    next_freq = FREQ_W'(F_LO_MAX);
                    next_mode = 1'b0;
                    wrap      = 1'b1;
                end else begin
                    next_freq = freq - FREQ_W'(STEP_HI);
                end
            end
        end
    end

endmodule

// File: rtl/freq_sweep_ctrl.sv
// Setpoint sequencer: manual steps, auto sweep with dwell, valid/ack delivery.
// Define SWEEP_PINGPONG_EN to make auto sweep reverse at the range extremes instead of wrapping.
module freq_sweep_ctrl
    import freq_ctrl_pkg::*;
#(
    parameter int FREQ_W    = 12,
    parameter int DWELL_CYC = 12_500_000,
    parameter int CNT_W     = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              step_up,
    input  logic              step_dn,
    input  logic              sweep_en,
    input  logic              dir,
    input  logic              freq_ack,
    output logic [FREQ_W-1:0] freq,
    output logic              mode,
    output logic              freq_valid,
    output logic              busy,
    output logic              wrap,
    output logic [1:0]        state
);

    // Handshake: freq/mode are offered while freq_valid=1 and are held until a
    // cycle with freq_ack=1; that edge completes the transfer and drops freq_valid.

    state_t             state_q;
    logic [CNT_W-1:0]   cnt;
    logic               manual_cmd;
    logic               auto_up;
    logic               auto_flip;
    logic               calc_up;
    logic [FREQ_W-1:0]  nxt_freq;
    logic               nxt_mode;
    logic               nxt_wrap;

    assign state      = state_q;
    assign manual_cmd = step_up ^ step_dn;

`ifdef SWEEP_PINGPONG_EN
    logic dir_q;
    logic at_top;
    logic at_bot;

    assign at_top    = mode && (freq == FREQ_W'(F_HI_MAX));
    assign at_bot    = !mode && (freq == FREQ_W'(F_LO_MIN));
    assign auto_up   = dir_q ? !at_top : at_bot;
    assign auto_flip = dir_q ? at_top : at_bot;
`else
    assign auto_up   = dir;
    assign auto_flip = 1'b0;
`endif

    assign calc_up = manual_cmd ? step_up : auto_up;

    freq_step_calc #(.FREQ_W(FREQ_W)) u_calc (
        .freq      (freq),
        .mode      (mode),
        .up        (calc_up),
        .next_freq (nxt_freq),
        .next_mode (nxt_mode),
        .wrap      (nxt_wrap)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            freq       <= FREQ_W'(F_LO_MIN);
            mode       <= 1'b0;
            freq_valid <= 1'b0;
            busy       <= 1'b0;
            wrap       <= 1'b0;
            cnt        <= '0;
`ifdef SWEEP_PINGPONG_EN
            dir_q      <= 1'b0;
`endif
        end else begin
            wrap <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (manual_cmd) begin
                        freq       <= nxt_freq;
                        mode       <= nxt_mode;
                        wrap       <= nxt_wrap;
                        freq_valid <= 1'b1;
                        busy       <= 1'b1;
                        state_q    <= OFFER;
                    end else if (sweep_en) begin
                        cnt     <= '0;
                        state_q <= DWELL;
`ifdef SWEEP_PINGPONG_EN
                        dir_q   <= dir;
`endif
                    end
                end
                OFFER: begin
                    if (freq_ack) begin
                        freq_valid <= 1'b0;
                        busy       <= 1'b0;
                        cnt        <= '0;
                        state_q    <= sweep_en ? DWELL : IDLE;
                    end
                end
                DWELL: begin
                    if (manual_cmd) begin
                        freq       <= nxt_freq;
                        mode       <= nxt_mode;
                        wrap       <= nxt_wrap;
                        freq_valid <= 1'b1;
                        busy       <= 1'b1;
                        cnt        <= '0;
                        state_q    <= OFFER;
                    end else if (!sweep_en) begin
                        cnt     <= '0;
                        state_q <= IDLE;
                    end else if (cnt == CNT_W'(DWELL_CYC - 1)) begin
                        freq       <= nxt_freq;
                        mode       <= nxt_mode;
                        wrap       <= nxt_wrap;
                        freq_valid <= 1'b1;
                        busy       <= 1'b1;
                        cnt        <= '0;
                        state_q    <= OFFER;
`ifdef SWEEP_PINGPONG_EN
                        if (auto_flip) dir_q <= ~dir_q;
`endif
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // auto_flip only drives the ping-pong direction register.
    logic unused_ok;
    assign unused_ok = auto_flip;

endmodule

// File: tb/tb_freq_sweep_ctrl.sv
// Directed bench for freq_sweep_ctrl with a short dwell so auto sweep is observable.
module tb_freq_sweep_ctrl;
    import freq_ctrl_pkg::*;

    localparam int FREQ_W = 12;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              step_up = 1'b0;
    logic              step_dn = 1'b0;
    logic              sweep_en = 1'b0;
    logic              dir = 1'b1;
    logic              freq_ack = 1'b0;
    logic [FREQ_W-1:0] freq;
    logic              mode;
    logic              freq_valid;
    logic              busy;
    logic              wrap;
    logic [1:0]        state_dbg;

    int n_checks = 0;
    int n_fail   = 0;

    freq_sweep_ctrl #(.FREQ_W(FREQ_W), .DWELL_CYC(4), .CNT_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .step_up    (step_up),
        .step_dn    (step_dn),
        .sweep_en   (sweep_en),
        .dir        (dir),
        .freq_ack   (freq_ack),
        .freq       (freq),
        .mode       (mode),
        .freq_valid (freq_valid),
        .busy       (busy),
        .wrap       (wrap),
        .state      (state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // drivers: inputs change on the falling edge, outputs are sampled there too
    task automatic pulse(input logic up, input logic dn);
        @(negedge clk);
        step_up = up;
        step_dn = dn;
        @(negedge clk);
        step_up = 1'b0;
        step_dn = 1'b0;
    endtask

    task automatic ack_offer();
        freq_ack = 1'b1;
        @(negedge clk);
        freq_ack = 1'b0;
    endtask

    task automatic do_step(input logic up);
        pulse(up, !up);
        ack_offer();
    endtask

    task automatic wait_valid(input int max_cyc, output int waited);
        waited = 0;
        while (!freq_valid && waited < max_cyc) begin
            @(negedge clk);
            waited++;
        end
        if (!freq_valid) check_eq("wait_valid_timeout", 32'(waited), 32'(max_cyc + 1));
    endtask

    int n;
    int seen;
    int exp_auto[4] = '{99, 100, 1000, 1100};

    initial begin
        // reset state
        #12;
        check_eq("rst_freq", 32'(freq), 1);
        check_eq("rst_mode", 32'(mode), 0);
        check_eq("rst_valid", 32'(freq_valid), 0);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_wrap", 32'(wrap), 0);
        check_eq("rst_state", 32'(state_dbg), 32'(IDLE));
        @(negedge clk);
        rst_n = 1'b1;

        // 1: three manual up steps
        for (int i = 0; i < 3; i++) begin
            pulse(1'b1, 1'b0);
            check_eq("up_freq", 32'(freq), 32'(2 + i));
            check_eq("up_valid", 32'(freq_valid), 1);
            check_eq("up_busy", 32'(busy), 1);
            check_eq("up_wrap", 32'(wrap), 0);
            ack_offer();
            check_eq("up_valid_drop", 32'(freq_valid), 0);
            check_eq("up_busy_drop", 32'(busy), 0);
        end

        // 2: 100 -> 1000 wrap and back
        for (int i = 0; i < 96; i++) do_step(1'b1);
        check_eq("at_100", 32'(freq), 100);
        pulse(1'b1, 1'b0);
        check_eq("wrap_up_freq", 32'(freq), 1000);
        check_eq("wrap_up_mode", 32'(mode), 1);
        check_eq("wrap_up_wrap", 32'(wrap), 1);
        @(negedge clk);
        check_eq("wrap_one_cycle", 32'(wrap), 0);
        ack_offer();
        pulse(1'b0, 1'b1);
        check_eq("wrap_dn_freq", 32'(freq), 100);
        check_eq("wrap_dn_mode", 32'(mode), 0);
        check_eq("wrap_dn_wrap", 32'(wrap), 1);
        ack_offer();

        // 3: 1 -> 2000 and 2000 -> 1
        for (int i = 0; i < 99; i++) do_step(1'b0);
        check_eq("at_1", 32'(freq), 1);
        pulse(1'b0, 1'b1);
        check_eq("bot_wrap_freq", 32'(freq), 2000);
        check_eq("bot_wrap_mode", 32'(mode), 1);
        check_eq("bot_wrap_wrap", 32'(wrap), 1);
        ack_offer();
        pulse(1'b1, 1'b0);
        check_eq("top_wrap_freq", 32'(freq), 1);
        check_eq("top_wrap_mode", 32'(mode), 0);
        check_eq("top_wrap_wrap", 32'(wrap), 1);
        ack_offer();

        // 4: steps dropped while the offer is pending; simultaneous steps ignored
        pulse(1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step_up = (i % 2 == 0);
            @(negedge clk);
        end
        step_up = 1'b0;
        check_eq("hold_freq", 32'(freq), 2);
        check_eq("hold_valid", 32'(freq_valid), 1);
        check_eq("hold_state", 32'(state_dbg), 32'(OFFER));
        ack_offer();
        check_eq("hold_after_ack", 32'(freq), 2);
        pulse(1'b1, 1'b0);
        check_eq("next_after_ack", 32'(freq), 3);
        ack_offer();
        pulse(1'b1, 1'b1);
        check_eq("both_valid", 32'(freq_valid), 0);
        check_eq("both_freq", 32'(freq), 3);
        check_eq("both_state", 32'(state_dbg), 32'(IDLE));

        // 5: auto sweep up from 98
        for (int i = 0; i < 95; i++) do_step(1'b1);
        check_eq("at_98", 32'(freq), 98);
        @(negedge clk);
        dir = 1'b1;
        sweep_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_valid(20, n);
            if (i > 0) check_eq("dwell_gap", 32'(n), 4);
            check_eq("auto_freq", 32'(freq), 32'(exp_auto[i]));
            check_eq("auto_mode", 32'(mode), (exp_auto[i] >= 1000) ? 1 : 0);
            if (i == 2) check_eq("auto_wrap", 32'(wrap), 1);
            ack_offer();
        end
        sweep_en = 1'b0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (freq_valid) seen++;
        end
        check_eq("sweep_off_offers", 32'(seen), 0);
        check_eq("sweep_off_state", 32'(state_dbg), 32'(IDLE));
        check_eq("sweep_off_freq", 32'(freq), 1100);

        // 6: reset while an offer is pending
        for (int i = 0; i < 3; i++) do_step(1'b1);
        pulse(1'b1, 1'b0);
        check_eq("pre_rst_freq", 32'(freq), 1500);
        check_eq("pre_rst_valid", 32'(freq_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_freq", 32'(freq), 1);
        check_eq("mid_rst_mode", 32'(mode), 0);
        check_eq("mid_rst_valid", 32'(freq_valid), 0);
        check_eq("mid_rst_busy", 32'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // auto sweep through the top extreme
        do_step(1'b0);
        do_step(1'b0);
        check_eq("at_1900", 32'(freq), 1900);
        dir = 1'b1;
        sweep_en = 1'b1;
        wait_valid(20, n);
        check_eq("pp_first", 32'(freq), 2000);
        ack_offer();
        wait_valid(20, n);
`ifdef SWEEP_PINGPONG_EN
        check_eq("pp_second", 32'(freq), 1900);
        check_eq("pp_second_mode", 32'(mode), 1);
        check_eq("pp_second_wrap", 32'(wrap), 0);
`else
        check_eq("pp_second", 32'(freq), 1);
        check_eq("pp_second_mode", 32'(mode), 0);
        check_eq("pp_second_wrap", 32'(wrap), 1);
`endif
        ack_offer();
        sweep_en = 1'b0;
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/freq_sweep_ctrl.md
Name: freq_sweep_ctrl

Overview:
Sequencer for the variable-frequency generator's setpoint register. It accepts debounced single-cycle step commands and an automatic sweep mode, and computes the next frequency setpoint across the two ranges: low range 1–100 Hz in steps of 1, high range 1000–2000 Hz in steps of 100. Each new setpoint is delivered to the generator and display datapath through a valid/ack handshake. It replaces the ad-hoc per-button update logic with a single clocked FSM.

Parameters:
FREQ_W, 12, width of the frequency setpoint in Hz.
DWELL_CYC, 12_500_000, clock cycles each setpoint is held during auto sweep (250 ms at 50 MHz). Minimum 2.
CNT_W, 24, width of the dwell counter. Must satisfy 2^CNT_W > DWELL_CYC.

Ports:
CLK  in  1  system clock, 50 MHz.
RST_N  in  1  asynchronous active-low reset.
STEP_UP  in  1  one-cycle pulse: advance one step up.
STEP_DN  in  1  one-cycle pulse: advance one step down.
SWEEP_EN  in  1  level: auto sweep enabled.
DIR  in  1  auto sweep direction; 1 = up, 0 = down.
FREQ_ACK  in  1  consumer accepts FREQ; valid only while FREQ_VALID = 1.
FREQ  out  FREQ_W  current setpoint in Hz.
MODE  out  1  range flag; 0 = 1–100 Hz, 1 = 1000–2000 Hz.
FREQ_VALID  out  1  new setpoint offered.
BUSY  out  1  high in OFFER state.
WRAP  out  1  one-cycle pulse when a step crosses ranges.

Behaviour:
- Clock and reset: one clock, CLK. Reset is asynchronous and active-low (RST_N). All registers clear immediately on RST_N = 0.
- Reset values: FREQ = 1, MODE = 0, FREQ_VALID = 0, BUSY = 0, WRAP = 0, dwell counter = 0, state = IDLE.
- States:
  - IDLE: no auto sweep; waiting for a command.
  - OFFER: FREQ_VALID = 1; waiting for FREQ_ACK.
  - DWELL: auto sweep hold, counting.
- Step rule (up), applied to the current FREQ/MODE:
  - MODE 0, FREQ < 100: FREQ + 1.
  - MODE 0, FREQ = 100: FREQ = 1000, MODE = 1, WRAP.
  - MODE 1, FREQ < 2000: FREQ + 100.
  - MODE 1, FREQ = 2000: FREQ = 1, MODE = 0, WRAP.
- Step rule (down):
  - MODE 0, FREQ > 1: FREQ - 1.
  - MODE 0, FREQ = 1: FREQ = 2000, MODE = 1, WRAP.
  - MODE 1, FREQ > 1000: FREQ - 100.
  - MODE 1, FREQ = 1000: FREQ = 100, MODE = 0, WRAP.
- Arithmetic: all arithmetic is unsigned FREQ_W-bit. No intermediate value may go below 0 or exceed 2000.
- Command accept: in IDLE or DWELL, a STEP_UP xor STEP_DN pulse at cycle n produces the following at n+1, then state goes to OFFER:
  - registered new FREQ/MODE;
  - FREQ_VALID = 1, BUSY = 1;
  - WRAP pulse if the step crossed ranges.
- Simultaneous commands: STEP_UP and STEP_DN in the same cycle are a no-op; no state change.
- OFFER:
  - FREQ, MODE and FREQ_VALID are held stable until FREQ_ACK = 1.
  - On the ack cycle, FREQ_VALID and BUSY drop on the next edge.
  - Next state is DWELL if SWEEP_EN = 1, else IDLE.
  - STEP pulses arriving in OFFER are dropped.
- DWELL:
  - The counter runs from 0 to DWELL_CYC-1.
  - At terminal count it performs an auto step in direction DIR, as a command accept, and clears the counter.
  - A manual STEP in DWELL takes precedence over the auto step and also clears the counter.
  - SWEEP_EN = 0 in DWELL goes to IDLE next cycle with the counter cleared.
- IDLE with SWEEP_EN = 1: goes to DWELL next cycle with the counter at 0.
- DIR changes take effect at the next auto step only.
- Reset mid-OFFER: the offer is abandoned; outputs return to reset values; no ack is required.

Optional Feature:
- Macro: SWEEP_PINGPONG_EN.
- When defined:
  - At the range extremes, auto steps reverse direction instead of wrapping: 2000 going up steps to 1900, and 1 going down steps to 2.
  - An internal direction register is loaded from DIR on IDLE→DWELL and toggles at each extreme.
  - WRAP still pulses on every 100↔1000 crossing.
  - Manual steps still wrap as in the step rules.
- When undefined: auto steps wrap exactly like manual steps, and DIR is used directly.

Decomposition:
- Package freq_ctrl_pkg:
  - constants F_LO_MIN = 1, F_LO_MAX = 100, F_HI_MIN = 1000, F_HI_MAX = 2000, STEP_LO = 1, STEP_HI = 100;
  - state enum {IDLE, OFFER, DWELL}.
- Sub-module freq_step_calc:
  - combinational; inputs FREQ, MODE, up/down;
  - outputs next FREQ, next MODE, wrap flag.
  - Shared by the manual and auto paths, and unit-testable in isolation.

Test Plan:
1. Reset release, FREQ = 1, MODE = 0; STEP_UP ×3, each acked one cycle later -> FREQ 2, 3, 4; FREQ_VALID high exactly one or more cycles per offer.
2. FREQ = 100, MODE 0; STEP_UP -> FREQ = 1000, MODE = 1, WRAP high for one cycle. Then at FREQ = 1000, STEP_DN -> FREQ = 100, MODE = 0, WRAP pulse.
3. FREQ = 1; STEP_DN -> 2000, MODE 1. Then at 2000, STEP_UP -> 1, MODE 0.
4. FREQ_ACK held low for 10 cycles while STEP_UP pulses -> FREQ stable, pulses dropped, one increment only after ack. STEP_UP and STEP_DN in the same cycle -> no offer.
5. DWELL_CYC = 4, SWEEP_EN = 1, DIR = 1, immediate acks from FREQ = 98 -> offers 99, 100, 1000, 1100 spaced by dwell plus handshake. SWEEP_EN dropped in DWELL -> IDLE, no further offers.
6. RST_N asserted while FREQ_VALID = 1 at FREQ = 1500 -> outputs immediately FREQ = 1, MODE = 0, VALID = 0. With SWEEP_PINGPONG_EN at 1900 going up, DWELL_CYC = 4 -> 2000, then 1900.
